// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Enumerates arbiter states and converts one-hot grants to indices.
package arb_pkg;

    localparam int ARB_MAX_REQ  = 16;
    localparam int ARB_MIN_HOLD = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic logic [3:0] onehot2bin(
        input logic [ARB_MAX_REQ-1:0] oh
    );
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < ARB_MAX_REQ; i++) begin
            if (oh[i]) b = b | 4'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// The arbiter uses the slave view, requesters the master view.
interface rr_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               busy;
    logic               hold_expired;

    modport master (
        output req,
        input  gnt, gnt_id, busy, hold_expired
    );

    modport slave (
        input  req,
        output gnt, gnt_id, busy, hold_expired
    );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Masked rotating priority encoder: first candidate at or after ptr wins.
// Purely combinational; the arbiter registers its result.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_REQ-1:0] excl,
    output logic [NUM_REQ-1:0] win,
    output logic               vld
);

    logic [NUM_REQ-1:0] cand;

    assign cand = req & ~excl;

    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!vld && cand[idx]) begin
                win[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant.
// RR_ARBITER_HOLD_LIMIT_EN enables forced rotation after MAX_HOLD cycles.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        nreset,
    rr_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
        $error("rr_arbiter: NUM_REQ out of range");
    end
    if (MAX_HOLD < ARB_MIN_HOLD) begin : g_bad_max_hold
        $error("rr_arbiter: MAX_HOLD too small");
    end

    arb_state_t         state;
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] win;
    logic               win_vld;
    logic [3:0]         win_id4;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    nxt_ptr;
    logic               owner_req;

    // The current owner is masked so a forced rotation never re-picks it.
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req  (bus.req),
        .ptr  (ptr),
        .excl (gnt_q),
        .win  (win),
        .vld  (win_vld)
    );

    assign owner_req = |(bus.req & gnt_q);
    assign win_id4   = onehot2bin(ARB_MAX_REQ'(win));
    assign win_id    = win_id4[ID_W-1:0];
    assign nxt_ptr   = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);

`ifdef RR_ARBITER_HOLD_LIMIT_EN
    localparam int HC_W = $clog2(MAX_HOLD);

    logic [HC_W-1:0] hold_cnt;
    logic            hold_exp_q;
    logic            at_lim;

    assign at_lim = (hold_cnt == HC_W'(MAX_HOLD-1));
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr      <= '0;
`ifdef RR_ARBITER_HOLD_LIMIT_EN
            hold_cnt   <= '0;
            hold_exp_q <= 1'b0;
`endif
        end else begin
`ifdef RR_ARBITER_HOLD_LIMIT_EN
            hold_exp_q <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        state    <= OWN;
                        gnt_q    <= win;
                        gnt_id_q <= win_id;
                        ptr      <= nxt_ptr;
`ifdef RR_ARBITER_HOLD_LIMIT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                OWN: begin
                    if (!owner_req) begin
                        if (win_vld) begin
                            gnt_q    <= win;
                            gnt_id_q <= win_id;
                            ptr      <= nxt_ptr;
`ifdef RR_ARBITER_HOLD_LIMIT_EN
                            hold_cnt <= '0;
`endif
                        end else begin
                            state <= IDLE;
                            gnt_q <= '0;
                        end
                    end
`ifdef RR_ARBITER_HOLD_LIMIT_EN
                    else if (at_lim) begin
                        hold_cnt <= '0;
                        if (win_vld) begin
                            gnt_q      <= win;
                            gnt_id_q   <= win_id;
                            ptr        <= nxt_ptr;
                            hold_exp_q <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
`endif
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = |gnt_q;
`ifdef RR_ARBITER_HOLD_LIMIT_EN
    assign bus.hold_expired = hold_exp_q;
`else
    assign bus.hold_expired = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with a reference-model scoreboard.
// Hold-limit steps follow RR_ARBITER_HOLD_LIMIT_EN.
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;
`ifdef RR_ARBITER_HOLD_LIMIT_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       hx;
    } exp_t;

    logic clk;
    logic nreset;

    rr_arbiter_if #(.NUM_REQ(N)) ifc ();

    rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    exp_t sb[$];

    bit m_own;
    int m_owner;
    int m_ptr;
    int m_cnt;
    int m_gid;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own   = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_gid   = 0;
    endtask

    // Reference behaviour: predict outputs after the next edge for req r.
    task automatic model_push(input logic [3:0] r);
        exp_t e;
        bit   pulse;
        bit   keep;
        int   w;
        pulse = 1'b0;
        keep  = m_own && r[m_owner] && !(HOLD && m_cnt == MH-1);
        if (keep) begin
            m_cnt++;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (w < 0 && r[idx] && !(m_own && idx == m_owner)) w = idx;
            end
            if (w >= 0) begin
                pulse   = m_own && r[m_owner];
                m_owner = w;
                m_own   = 1'b1;
                m_gid   = w;
                m_ptr   = (w + 1) % N;
                m_cnt   = 0;
            end else if (m_own && r[m_owner]) begin
                m_cnt = 0;
            end else begin
                m_own = 1'b0;
            end
        end
        e.gnt  = m_own ? 4'(1 << m_owner) : 4'b0;
        e.id   = 2'(m_gid);
        e.busy = m_own;
        e.hx   = pulse;
        sb.push_back(e);
    endtask

    task automatic step(input logic [3:0] r);
        exp_t e;
        ifc.req = r;
        model_push(r);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt", 32'(ifc.gnt), 32'(e.gnt));
        chk("gnt_id", 32'(ifc.gnt_id), 32'(e.id));
        chk("busy", 32'(ifc.busy), 32'(e.busy));
        chk("hold_expired", 32'(ifc.hold_expired), 32'(e.hx));
        chk("onehot0", 32'($onehot0(ifc.gnt)), 32'(1));
    endtask

    initial begin
        logic [3:0] first;
        bit         seen;
        int         hx_cnt;

        model_reset();
        nreset  = 1'b0;
        ifc.req = '0;

        // Reset with random requests: outputs stay cleared.
        for (int i = 0; i < 4; i++) begin
            ifc.req = 4'($urandom_range(1, 15));
            @(posedge clk);
            #1;
            chk("rst_gnt", 32'(ifc.gnt), 32'(0));
            chk("rst_id", 32'(ifc.gnt_id), 32'(0));
            chk("rst_busy", 32'(ifc.busy), 32'(0));
            chk("rst_hx", 32'(ifc.hold_expired), 32'(0));
        end
        ifc.req = '0;
        nreset  = 1'b1;
        @(posedge clk);
        #1;

        // Single request and release.
        step(4'b0001);
        chk("single_gnt", 32'(ifc.gnt), 32'(4'b0001));
        chk("single_id", 32'(ifc.gnt_id), 32'(0));
        step(4'b0000);
        chk("single_drop", 32'(ifc.gnt), 32'(0));

        // Zero-bubble handoff 1 -> 3.
        step(4'b0010);
        chk("ho_own1", 32'(ifc.gnt), 32'(4'b0010));
        step(4'b1000);
        chk("ho_own3", 32'(ifc.gnt), 32'(4'b1000));
        step(4'b0000);

        // All request continuously.
        hx_cnt = 0;
        for (int i = 0; i < 34; i++) begin
            step(4'b1111);
            if (ifc.hold_expired) hx_cnt++;
        end
        chk("rot_pulses", 32'(hx_cnt), HOLD ? 32'(4) : 32'(0));

        // Release-driven rotation while others keep requesting.
        step(4'b1111 & ~ifc.gnt);
        step(4'b1111 & ~ifc.gnt);
        step(4'b0000);
        step(4'b0000);

        // Lone hog never expires, then a rival appears.
        hx_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0100);
            if (ifc.hold_expired) hx_cnt++;
        end
        chk("hog_pulses", 32'(hx_cnt), 32'(0));
        chk("hog_gnt", 32'(ifc.gnt), 32'(4'b0100));
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0101);
            if (ifc.gnt == 4'b0001) seen = 1'b1;
        end
        chk("hog_rival", 32'(seen), HOLD ? 32'(1) : 32'(0));
        step(4'b0000);

        // Two steady requesters.
        step(4'b0011);
        first  = ifc.gnt;
        hx_cnt = 0;
        for (int i = 0; i < 29; i++) begin
            step(4'b0011);
            if (ifc.gnt != first) hx_cnt++;
        end
        chk("pair_switches", 32'(hx_cnt != 0), HOLD ? 32'(1) : 32'(0));
        step(4'b0000);

        // Asynchronous reset in the middle of a grant.
        step(4'b0010);
        chk("pre_rst_busy", 32'(ifc.busy), 32'(1));
        #2;
        nreset = 1'b0;
        #1;
        chk("async_gnt", 32'(ifc.gnt), 32'(0));
        chk("async_busy", 32'(ifc.busy), 32'(0));
        chk("async_id", 32'(ifc.gnt_id), 32'(0));
        model_reset();
        ifc.req = '0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        step(4'b0100);
        chk("post_rst_gnt", 32'(ifc.gnt), 32'(4'b0100));
        step(4'b0000);

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
